// File: rtl/logic_op_arbiter_if.sv
// rtl/logic_op_arbiter_if.sv - request/response bus between requesters and logic_op_arbiter
// Purpose: groups the per-requester request lanes and the single tagged result channel.
// Ports (signals):
//   req_valid/req_ready  per-requester handshake, req_ready one-hot or zero
//   req_op/req_a/req_b   packed per-requester op (2 bits) and operands (WIDTH bits), slice i
//   resp_valid/resp_ready result handshake
//   resp_data/resp_id/resp_zero  result, owning requester, result-is-zero flag
// Modports: master = requester/consumer side, slave = arbiter side.
interface logic_op_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic [IDW-1:0]        resp_id;
  logic                  resp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_zero
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin arbiter sharing one bitwise logic unit among NREQ requesters
// Purpose: grants one requester per IDLE visit (rotating priority), executes AND/OR/XOR/NAND
//          on the latched operands for one cycle, then holds a tagged registered result.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          logic_op_arbiter_if.slave request/response bus
//   busy         high whenever the sequencer is not idle
//   done_count   completed responses, wraps at 16 bits
module logic_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_op_arbiter_if.slave     bus,
  output logic                  busy,
  output logic [15:0]           done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [IDW-1:0]   winner;
  logic             found;
  logic [WIDTH-1:0] result;

  logic [1:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = bus.req_op[2*i +: 2];
      a_arr[i]  = bus.req_a[WIDTH*i +: WIDTH];
      b_arr[i]  = bus.req_b[WIDTH*i +: WIDTH];
    end
  end

  // Scan from the farthest candidate back to ptr so the nearest valid
  // requester (in rotating order) is the last one written and wins.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 32'(ptr) + 32'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      cand = idx[IDW-1:0];
      if (bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Grant is combinational so the requester sees it in the same IDLE cycle;
  // held low while reset is asserted so no transfer can be taken then.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == IDLE && found) bus.req_ready[winner] = 1'b1;
  end

  always_comb begin
    case (op_q)
      2'b00:   result = a_q & b_q;
      2'b01:   result = a_q | b_q;
      2'b10:   result = a_q ^ b_q;
      default: result = ~(a_q & b_q);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      id_q           <= '0;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
      bus.resp_zero  <= 1'b0;
      busy           <= 1'b0;
      done_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready mirrors the winner's valid, so found implies a transfer.
          if (found) begin
            op_q  <= op_arr[winner];
            a_q   <= a_arr[winner];
            b_q   <= b_arr[winner];
            id_q  <= winner;
            ptr   <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          bus.resp_data  <= result;
          bus.resp_zero  <= (result == '0);
          bus.resp_id    <= id_q;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            done_count     <= done_count + 16'd1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - scoreboard bench for logic_op_arbiter
module tb_logic_op_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] done_count;

  logic_op_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    int               acc_cyc;
    bit               seen;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_ptr = 0;
  int   model_done = 0;
  bit   inflight = 1'b0;
  int   acc_id = -1;

  always @(posedge clk) cyc++;

  function automatic logic [WIDTH-1:0] ref_op(logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    vectors++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One clock: check grants at the falling edge, record accepts, return just after the rising edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int w;
    @(negedge clk);
    acc_id  = -1;
    exp_rdy = '0;
    if (!inflight && rst_n) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (model_ptr + k) % NREQ;
        if (w < 0 && bus.req_valid[j]) w = j;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(inflight));
    for (int i = 0; i < NREQ; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) acc_id = i;
    if (acc_id >= 0) begin
      sb.push_back('{acc_id,
                     ref_op(bus.req_op[2*acc_id +: 2], bus.req_a[WIDTH*acc_id +: WIDTH],
                            bus.req_b[WIDTH*acc_id +: WIDTH]),
                     cyc, 1'b0});
      model_ptr = (acc_id + 1) % NREQ;
      inflight  = 1'b1;
    end
    if (bus.resp_valid && bus.resp_ready) inflight = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented response is compared against the scoreboard front.
  always @(negedge clk) begin
    if (rst_n) begin
      check("done_count", 32'(done_count), 32'(model_done));
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          if (!sb[0].seen) begin
            check("resp_latency", 32'(cyc), 32'(sb[0].acc_cyc + 2));
            sb[0].seen = 1'b1;
          end
          check("resp_data", 32'(bus.resp_data), 32'(sb[0].data));
          check("resp_id", 32'(bus.resp_id), 32'(sb[0].id));
          check("resp_zero", 32'(bus.resp_zero), 32'(sb[0].data == '0));
          if (bus.resp_ready) begin
            void'(sb.pop_front());
            model_done = (model_done + 1) & 32'hFFFF;
          end
        end
      end
    end
  end

  task automatic set_req(int id, logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    bus.req_op[2*id +: 2]       = op;
    bus.req_a[WIDTH*id +: WIDTH] = a;
    bus.req_b[WIDTH*id +: WIDTH] = b;
  endtask

  task automatic issue(int id, logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    set_req(id, op, a, b);
    bus.req_valid[id] = 1'b1;
    acc_id = -1;
    for (int n = 0; n < 20 && acc_id != id; n++) step();
    if (acc_id != id) fail_now("accept_timeout");
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (inflight || sb.size() != 0); n++) step();
    if (inflight || sb.size() != 0) fail_now("drain_timeout");
    step();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
    check({tag, "_resp_data"}, 32'(bus.resp_data), 32'h0);
    check({tag, "_resp_id"}, 32'(bus.resp_id), 32'h0);
    check({tag, "_resp_zero"}, 32'(bus.resp_zero), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done_count"}, 32'(done_count), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid [8];
    int gcyc[8];
    int ng;

    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single op on requester 0.
    issue(0, 2'b00, 8'hF0, 8'h3C);
    drain();
    check("single_done", 32'(done_count), 32'd1);

    // Op coverage on requester 2.
    issue(2, 2'b01, 8'hAA, 8'h0F); drain();
    issue(2, 2'b10, 8'hAA, 8'h0F); drain();
    issue(2, 2'b11, 8'hAA, 8'h0F); drain();
    issue(2, 2'b00, 8'hAA, 8'h55); drain();

    // Back-pressure: consumer stalls for several cycles.
    bus.resp_ready = 1'b0;
    issue(1, 2'b10, 8'h5A, 8'hC3);
    repeat (6) step();
    check("bp_held", 32'(sb.size()), 32'd1);
    bus.resp_ready = 1'b1;
    drain();

    // Reset during EXEC discards the operation.
    issue(1, 2'b01, 8'h12, 8'h34);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    inflight   = 1'b0;
    model_ptr  = 0;
    model_done = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue(3, 2'b11, 8'h0F, 8'hFF);
    drain();
    check("midreset_done", 32'(done_count), 32'd1);

    // Fairness with all requesters continuously valid.
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      bus.req_valid[i] = 1'b1;
    end
    ng = 0;
    for (int n = 0; n < 60 && ng < 8; n++) begin
      step();
      if (acc_id >= 0) begin
        gid[ng]  = acc_id;
        gcyc[ng] = cyc;
        ng++;
        set_req(acc_id, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      end
    end
    bus.req_valid = '0;
    check("fair_count", 32'(ng), 32'd8);
    for (int k = 0; k < ng; k++) begin
      check("fair_order", 32'(gid[k]), 32'(k % NREQ));
      if (k > 0) check("fair_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    end
    drain();

    // Counter wrap.
    force dut.done_count = 16'hFFFF;
    model_done = 32'hFFFF;
    step();
    release dut.done_count;
    step();
    issue(0, 2'b10, 8'h81, 8'h18);
    drain();
    check("wrap_done", 32'(done_count), 32'h0);

    // Randomised traffic with random consumer stalls.
    for (int n = 0; n < 400; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (acc_id == i) begin
          if ($urandom_range(0, 1) == 0)
            set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
          else
            bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 9) < 3) begin
            set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            bus.req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.resp_ready = ($urandom_range(0, 9) < 7);
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
